// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command sequencer.
//   state_e     : sequencer state encoding (3 bits)
//   OP_WRITE/OP_READ : frame opcodes
//   is_opcode() : true when a byte starts a known frame
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_BUS  = 3'd4,
    S_RSP  = 3'd5
  } state_e;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// uart_cmd_timer: inter-byte timeout counter for the command sequencer.
// Loads TIMEOUT_CLKS-1 on i_clr, counts down while i_en, and pulses o_expire
// in the cycle it sits at zero with i_en high. i_clr has priority, so a byte
// arriving in the expiry cycle suppresses the pulse and restarts the count.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : reload (new byte strobe)
//   i_en           : count enable (frame being received)
//   o_expire       : single-cycle timeout pulse
module uart_cmd_timer #(
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)                       cnt_d = LOAD;
    else if (i_en && cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  assign o_expire = i_en && !i_clr && (cnt_q == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= LOAD;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses bytes from uart_rx into command frames and issues
// single-byte register bus reads/writes; read data returns on a byte stream.
//   WRITE frame = {8'h57, addr, data}, READ frame = {8'h52, addr}.
// Optional build macro UART_CMD_CHECKSUM_EN: every frame carries a trailing
// byte equal to the XOR of all preceding frame bytes; a mismatch drops the
// frame and counts an error. Port list is identical either way.
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_rx_data, i_rx_valid   : byte from uart_rx (new byte on valid 0->1)
//   o_bus_req/we/addr/wdata : bus request, held until i_bus_ack
//   i_bus_ack, i_bus_rdata  : bus completion and read data
//   o_rsp_data/valid, i_rsp_ready : read response stream
//   o_err_count             : saturating frame-error count
//   o_busy                  : sequencer not idle
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 1024,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_bus_req,
  output logic                 o_bus_we,
  output logic [7:0]           o_bus_addr,
  output logic [7:0]           o_bus_wdata,
  input  logic                 i_bus_ack,
  input  logic [7:0]           i_bus_rdata,
  output logic [7:0]           o_rsp_data,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [ERR_CNT_W-1:0] o_err_count,
  output logic                 o_busy
);

  state_e               state_q, state_d;
  logic                 valid_q;
  logic                 we_q, we_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 req_q, req_d;
  logic [7:0]           rsp_data_q, rsp_data_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic strobe, expire, timer_en, err_inc, frame_done, csum_ok;

  // Only the rising edge of the uart_rx valid level marks a new byte.
  assign strobe   = i_rx_valid && !valid_q;
  assign timer_en = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CSUM);

  uart_cmd_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (strobe),
    .i_en     (timer_en),
    .o_expire (expire)
  );

`ifdef UART_CMD_CHECKSUM_EN
  // Running XOR of the frame; the opcode byte seeds it from idle.
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (strobe) csum_d = (state_q == S_IDLE) ? i_rx_data : (csum_q ^ i_rx_data);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign csum_ok = (i_rx_data == csum_q);
`else
  assign csum_ok = 1'b0;
`endif

  // NOTE: every variable assigned here gets a default first so no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_d       = req_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    err_inc     = 1'b0;
    frame_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (strobe) begin
          if (is_opcode(i_rx_data)) begin
            we_d    = (i_rx_data == OP_WRITE);
            state_d = S_ADDR;
          end else begin
            err_inc = 1'b1;  // unknown opcode: stay idle and resync on next byte
          end
        end
      end
      S_ADDR: begin
        if (strobe) begin
          addr_d = i_rx_data;
          if (we_q) state_d = S_DATA;
          else      frame_done = 1'b1;
        end else if (expire) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (strobe) begin
          wdata_d    = i_rx_data;
          frame_done = 1'b1;
        end else if (expire) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      S_CSUM: begin
        if (strobe) begin
          if (csum_ok) begin
            state_d = S_BUS;
            req_d   = 1'b1;
          end else begin
            err_inc = 1'b1;
            state_d = S_IDLE;
          end
        end else if (expire) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      S_BUS: begin
        if (strobe) err_inc = 1'b1;  // overrun: byte dropped, transfer continues
        if (req_q && i_bus_ack) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = S_IDLE;
          end else begin
            rsp_data_d  = i_bus_rdata;
            rsp_valid_d = 1'b1;
            state_d     = S_RSP;
          end
        end
      end
      S_RSP: begin
        if (strobe) err_inc = 1'b1;
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UART_CMD_CHECKSUM_EN
    if (frame_done) state_d = S_CSUM;
`else
    if (frame_done) begin
      state_d = S_BUS;
      req_d   = 1'b1;
    end
`endif

    // All error sources fold into one increment, so coincident errors count once.
    err_d = (err_inc && err_q != '1) ? err_q + 1'b1 : err_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      valid_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_q       <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= i_rx_valid;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_q       <= req_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  assign o_bus_req   = req_q;
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = wdata_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_err_count = err_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: scoreboard bench for uart_cmd_ctrl. Stimulus pushes the
// expected bus transactions and read responses into queues; a bus responder
// and a response monitor pop and compare whenever the DUT presents them.
// Build with +define+UART_CMD_CHECKSUM_EN to exercise the checksum variant.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int TO = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       bus_req, bus_we;
  logic [7:0] bus_addr, bus_wdata;
  logic       bus_ack = 1'b0;
  logic [7:0] bus_rdata = '0;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] err_count;
  logic       busy;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.TIMEOUT_CLKS(TO), .ERR_CNT_W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_bus_req   (bus_req),
    .o_bus_we    (bus_we),
    .o_bus_addr  (bus_addr),
    .o_bus_wdata (bus_wdata),
    .i_bus_ack   (bus_ack),
    .i_bus_rdata (bus_rdata),
    .o_rsp_data  (rsp_data),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_err_count (err_count),
    .o_busy      (busy)
  );

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         ack_dly;   // negative: never ack (reset test)
    int         req_cyc;
  } bus_t;

  typedef struct {
    logic [7:0] data;
    int         ready_dly;
  } rsp_t;

  bus_t       exp_bus[$];
  rsp_t       exp_rsp[$];
  logic [7:0] exp_err = '0;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push, input bus_t item);
    bus_t it;
    @(negedge clk);
    if (push) begin
      it = item;
      it.req_cyc = cyc + 1;
      exp_bus.push_back(it);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends a complete frame (plus checksum in the checksum build); the
  // expected bus item is queued with the final byte when push is set.
  task automatic send_frame(input logic we, input logic [7:0] addr, input logic [7:0] data,
                            input bit push, input bus_t item);
    logic [7:0] q[$];
    logic [7:0] cs;
    q.push_back(we ? OP_WRITE : OP_READ);
    q.push_back(addr);
    if (we) q.push_back(data);
    cs = '0;
    foreach (q[i]) cs = cs ^ q[i];
`ifdef UART_CMD_CHECKSUM_EN
    q.push_back(cs);
`endif
    for (int i = 0; i < q.size(); i++) send_byte(q[i], push && (i == q.size() - 1), item);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!bus_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, bus_req, 1'b1);
  endtask

  function automatic bus_t mk(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                              input logic [7:0] rdata, input int ack_dly);
    bus_t b;
    b.we = we; b.addr = addr; b.wdata = wdata; b.rdata = rdata;
    b.ack_dly = ack_dly; b.req_cyc = 0;
    return b;
  endfunction

  // Bus responder / monitor
  initial begin : bus_mon
    bus_t       e;
    logic       stable;
    logic [7:0] cap_addr, cap_wdata;
    logic       cap_we;
    forever begin
      @(negedge clk);
      if (rst_n && bus_req) begin
        cap_we = bus_we; cap_addr = bus_addr; cap_wdata = bus_wdata;
        if (exp_bus.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: addr=%0h we=%0b with nothing queued", bus_addr, bus_we);
          e = mk(bus_we, bus_addr, bus_wdata, 8'h00, 0);
        end else begin
          e = exp_bus.pop_front();
          check("req_we", bus_we, e.we);
          check("req_addr", bus_addr, e.addr);
          if (e.we) check("req_wdata", bus_wdata, e.wdata);
          check("req_latency", cyc, e.req_cyc);
        end
        if (e.ack_dly < 0) begin
          for (int i = 0; i < 200 && bus_req; i++) @(negedge clk);
        end else begin
          stable = 1'b1;
          for (int i = 0; i < e.ack_dly; i++) begin
            @(negedge clk);
            if (!bus_req || bus_we !== cap_we || bus_addr !== cap_addr || bus_wdata !== cap_wdata)
              stable = 1'b0;
          end
          if (e.ack_dly > 0) check("req_hold", stable, 1'b1);
          bus_ack   = 1'b1;
          bus_rdata = e.rdata;
          @(negedge clk);
          bus_ack   = 1'b0;
          bus_rdata = 8'h00;
          check("req_drop", bus_req, 1'b0);
        end
      end
    end
  end

  // Response monitor
  initial begin : rsp_mon
    rsp_t       r;
    logic       stable;
    logic [7:0] cap;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        cap = rsp_data;
        if (exp_rsp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: data=%0h with nothing queued", rsp_data);
          r.data = rsp_data;
          r.ready_dly = 0;
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_data", rsp_data, r.data);
        end
        stable = 1'b1;
        for (int i = 0; i < r.ready_dly; i++) begin
          @(negedge clk);
          if (!rsp_valid || rsp_data !== cap) stable = 1'b0;
        end
        if (r.ready_dly > 0) check("rsp_hold", stable, 1'b1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus_t none;
    rsp_t rr;
    none = mk(1'b0, 8'h00, 8'h00, 8'h00, 0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", bus_req, 1'b0);
    check("rst_we", bus_we, 1'b0);
    check("rst_addr", bus_addr, 8'h00);
    check("rst_wdata", bus_wdata, 8'h00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_err", err_count, 8'h00);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 57,10,A5, ack after 3 clocks
    send_frame(1'b1, 8'h10, 8'hA5, 1'b1, mk(1'b1, 8'h10, 8'hA5, 8'h00, 3));
    wait_idle("t1_idle");
    // Write with ack in the cycle req rises
    send_frame(1'b1, 8'h33, 8'hC4, 1'b1, mk(1'b1, 8'h33, 8'hC4, 8'h00, 0));
    wait_idle("t1b_idle");

    // Read 52,20 -> 3C, ready held low 5 clocks
    rr.data = 8'h3C; rr.ready_dly = 5;
    exp_rsp.push_back(rr);
    send_frame(1'b0, 8'h20, 8'h00, 1'b1, mk(1'b0, 8'h20, 8'h00, 8'h3C, 2));
    wait_idle("t2_idle");
    check("t2_err", err_count, exp_err);

    // Bad opcode in idle, then a normal write
    send_byte(8'h00, 1'b0, none);
    exp_err++;
    repeat (3) @(negedge clk);
    check("t3_err", err_count, exp_err);
    check("t3_busy", busy, 1'b0);
    send_frame(1'b1, 8'h01, 8'h02, 1'b1, mk(1'b1, 8'h01, 8'h02, 8'h00, 1));
    wait_idle("t3_idle");

    // Gaps just under the timeout keep the frame alive
    send_byte(OP_WRITE, 1'b0, none);
    repeat (TO - 3) @(negedge clk);
    send_byte(8'h10, 1'b0, none);
    repeat (TO - 3) @(negedge clk);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'hA5, 1'b0, none);
    repeat (TO - 3) @(negedge clk);
    send_byte(8'hE2, 1'b1, mk(1'b1, 8'h10, 8'hA5, 8'h00, 1));
`else
    send_byte(8'hA5, 1'b1, mk(1'b1, 8'h10, 8'hA5, 8'h00, 1));
`endif
    wait_idle("t4_gap_idle");
    check("t4_gap_err", err_count, exp_err);

    // Timeout: 57,10 then silence
    send_byte(OP_WRITE, 1'b0, none);
    send_byte(8'h10, 1'b0, none);
    repeat (TO - 1) @(negedge clk);
    check("t4_busy_before_to", busy, 1'b1);
    @(negedge clk);
    exp_err++;
    check("t4_busy_after_to", busy, 1'b0);
    check("t4_err", err_count, exp_err);
    repeat (4) @(negedge clk);

    // Reset while the request is outstanding
    send_frame(1'b1, 8'h44, 8'h55, 1'b1, mk(1'b1, 8'h44, 8'h55, 8'h00, -1));
    wait_req("t4r_req_seen");
    #2 rst_n = 1'b0;
    #1;
    check("t4r_req_async", bus_req, 1'b0);
    check("t4r_busy_async", busy, 1'b0);
    check("t4r_err_cleared", err_count, 8'h00);
    exp_err = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t4r_no_replay", bus_req, 1'b0);

`ifdef UART_CMD_CHECKSUM_EN
    // Checksum good and bad
    send_byte(OP_WRITE, 1'b0, none);
    send_byte(8'h10, 1'b0, none);
    send_byte(8'hA5, 1'b0, none);
    send_byte(8'hE2, 1'b1, mk(1'b1, 8'h10, 8'hA5, 8'h00, 2));
    wait_idle("t5_good_idle");
    send_byte(OP_WRITE, 1'b0, none);
    send_byte(8'h10, 1'b0, none);
    send_byte(8'hA5, 1'b0, none);
    send_byte(8'h00, 1'b0, none);
    exp_err++;
    repeat (5) @(negedge clk);
    check("t5_bad_err", err_count, exp_err);
    check("t5_bad_busy", busy, 1'b0);
`endif

    // Overrun while the bus request is outstanding
    send_frame(1'b1, 8'h66, 8'h77, 1'b1, mk(1'b1, 8'h66, 8'h77, 8'h00, 6));
    wait_req("t6_req_seen");
    send_byte(8'h11, 1'b0, none);
    exp_err++;
    wait_idle("t6_bus_idle");
    check("t6_bus_overrun_err", err_count, exp_err);

    // Overrun while the read response waits
    rr.data = 8'h81; rr.ready_dly = 8;
    exp_rsp.push_back(rr);
    send_frame(1'b0, 8'h7E, 8'h00, 1'b1, mk(1'b0, 8'h7E, 8'h00, 8'h81, 1));
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    check("t6_rsp_seen", rsp_valid, 1'b1);
    send_byte(8'h99, 1'b0, none);
    exp_err++;
    wait_idle("t6_rsp_idle");
    check("t6_rsp_overrun_err", err_count, exp_err);

    // Saturation with 260 bad opcodes
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hFF, 1'b0, none);
      if (exp_err != 8'hFF) exp_err++;
      if (i == 99) begin
        @(negedge clk);
        check("t6_err_mid", err_count, exp_err);
      end
    end
    repeat (2) @(negedge clk);
    check("t6_err_sat", err_count, 8'hFF);
    send_frame(1'b1, 8'hF0, 8'h0F, 1'b1, mk(1'b1, 8'hF0, 8'h0F, 8'h00, 1));
    wait_idle("t6_post_sat_idle");
    check("t6_err_still_sat", err_count, 8'hFF);

    repeat (5) @(negedge clk);
    check("bus_queue_empty", exp_bus.size(), 0);
    check("rsp_queue_empty", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
